// File: rtl/serial_adder_ctrl.sv
// Bit-serial unsigned adder with an IDLE/RUN/DONE controller.
// One sum bit per enabled cycle, LSB first. The result is published only on the completion edge.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Full adder built from two half-add stages; returns {carry_out, sum_bit}.
    function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
        logic s1;
        logic c1;
        s1 = a ^ b;
        c1 = a & b;
        return {c1 | (s1 & c), s1 ^ c};
    endfunction

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_busy;
    logic             r_done;

    logic [1:0]       w_fa;
    logic [WIDTH-1:0] w_acc_next;

    assign w_fa = full_add(r_a[0], r_b[0], r_carry);

    // New bit enters at the MSB so that after WIDTH shifts the first bit sits at bit 0.
    generate
        if (WIDTH > 1) begin : g_shift
            assign w_acc_next = {w_fa[0], r_acc[WIDTH-1:1]};
        end else begin : g_single
            assign w_acc_next = w_fa[0];
        end
    endgenerate

    // Controller, serial datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= {WIDTH{1'b0}};
            r_b     <= {WIDTH{1'b0}};
            r_acc   <= {WIDTH{1'b0}};
            r_carry <= 1'b0;
            r_cnt   <= {CW{1'b0}};
            r_sum   <= {WIDTH{1'b0}};
            r_cout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else if (ena) begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= op_a;
                        r_b     <= op_b;
                        r_acc   <= {WIDTH{1'b0}};
                        r_carry <= 1'b0;
                        r_cnt   <= {CW{1'b0}};
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_acc   <= w_acc_next;
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_carry <= w_fa[1];
                    r_cnt   <= r_cnt + CW'(1);
                    if (r_cnt == LAST_BIT) begin
                        r_sum   <= w_acc_next;
                        r_cout  <= w_fa[1];
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= S_RUN;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: a cycle-count reference model predicts busy/done/result,
// expected sums are queued at acceptance and popped by a monitor on each done pulse.
module tb_serial_adder_ctrl;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             ena;
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int checks   = 0;
    int failures = 0;

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .start (start),
        .op_a  (op_a),
        .op_b  (op_b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: m_cnt counts enabled edges left until back in idle.
    // WIDTH+1 after acceptance; busy while >1, done when ==1.
    logic [WIDTH:0] exp_q[$];
    int             m_cnt     = 0;
    logic [WIDTH:0] m_pending = '0;
    logic [WIDTH:0] m_res     = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt     <= 0;
            m_res     <= '0;
            m_pending <= '0;
            exp_q.delete();
        end else if (ena) begin
            if (m_cnt == 0) begin
                if (start) begin
                    m_pending <= op_a + {1'b0, op_b};
                    exp_q.push_back(op_a + {1'b0, op_b});
                    m_cnt <= WIDTH + 1;
                end
            end else begin
                if (m_cnt == 2) m_res <= m_pending;
                m_cnt <= m_cnt - 1;
            end
        end
    end

    // Monitor: cycle-level output checks plus scoreboard pop on each new done pulse.
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        check("busy", busy, (m_cnt > 1));
        check("done", done, (m_cnt == 1));
        check("held_result", {cout, sum}, m_res);
        if (done && !prev_done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                check("scoreboard_result", {cout, sum}, exp_q.pop_front());
            end
        end
        prev_done = done;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Issue one addition; optional ena stall; returns edges from acceptance until done is seen.
    task automatic run_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input int stall_at, input int stall_len, input bit restart,
                           output int lat);
        int k;
        start = 1'b1;
        op_a  = a;
        op_b  = b;
        tick(1);
        start = restart;
        op_a  = WIDTH'($urandom);
        op_b  = WIDTH'($urandom);
        if (restart) begin
            op_a = {WIDTH{1'b1}};
            op_b = {WIDTH{1'b1}};
        end
        k = 0;
        while (!done && k < 100) begin
            ena = (k >= stall_at && k < stall_at + stall_len) ? 1'b0 : 1'b1;
            tick(1);
            k++;
        end
        ena   = 1'b1;
        start = 1'b0;
        if (k >= 100) check("done_timeout", 1, 0);
        lat = k;
        tick(1);
    endtask

    initial begin
        int lat;
        rst_n = 1'b0;
        ena   = 1'b1;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        tick(3);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_sum", sum, 0);
        check("reset_cout", cout, 0);
        rst_n = 1'b1;
        tick(2);

        run_add(8'h00, 8'h00, 100, 0, 1'b0, lat);
        check("latency_plain", lat, WIDTH);
        check("zero_sum", {cout, sum}, 9'h000);

        run_add(8'hFF, 8'h01, 100, 0, 1'b0, lat);
        check("ovf_sum", {cout, sum}, 9'h100);

        run_add(8'hA5, 8'h5A, 100, 0, 1'b0, lat);
        check("alt_sum", {cout, sum}, 9'h0FF);

        // start held during RUN/DONE must be ignored
        run_add(8'h12, 8'h34, 100, 0, 1'b1, lat);
        check("ignore_start_sum", {cout, sum}, 9'h046);
        tick(2);
        check("no_second_done", busy, 0);

        run_add(8'h0F, 8'h01, 3, 5, 1'b0, lat);
        check("latency_stall", lat, WIDTH + 5);
        check("stall_sum", {cout, sum}, 9'h010);

        // reset in the middle of an addition
        start = 1'b1;
        op_a  = 8'h80;
        op_b  = 8'h80;
        tick(1);
        start = 1'b0;
        tick(4);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_result", {cout, sum}, 9'h000);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        run_add(8'h80, 8'h80, 100, 0, 1'b0, lat);
        check("after_reset_sum", {cout, sum}, 9'h100);
        check("after_reset_latency", lat, WIDTH);

        // back-to-back with start held high
        start = 1'b1;
        repeat (20 * (WIDTH + 2)) begin
            op_a = WIDTH'($urandom);
            op_b = WIDTH'($urandom);
            tick(1);
        end
        start = 1'b0;

        // random enable and start traffic
        repeat (600) begin
            ena   = ($urandom_range(0, 3) != 0);
            start = ($urandom_range(0, 2) != 0);
            op_a  = WIDTH'($urandom);
            op_b  = WIDTH'($urandom);
            tick(1);
        end
        ena   = 1'b1;
        start = 1'b0;

        begin
            int k = 0;
            while ((exp_q.size() != 0 || busy || done) && k < 200) begin
                tick(1);
                k++;
            end
            if (k >= 200) check("drain_timeout", 1, 0);
        end
        check("queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 8, operand width in bits (legal range 2..16).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port ena, input, 1 bit: clock-enable; when 0, all internal state and outputs hold.
REQ-005 The block SHALL have port start, input, 1 bit: request to add op_a and op_b.
REQ-006 The block SHALL have port op_a, input, WIDTH bits: first operand, sampled only on an accepted start.
REQ-007 The block SHALL have port op_b, input, WIDTH bits: second operand, sampled only on an accepted start.
REQ-008 The block SHALL have port busy, output, 1 bit: high while an addition is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse marking a completed addition.
REQ-010 The block SHALL have port sum, output, WIDTH bits: registered result sum bits.
REQ-011 The block SHALL have port cout, output, 1 bit: registered result carry-out.

Function
REQ-012 The block SHALL add op_a+op_b bit-serially, LSB first, one bit per enabled cycle, through a single 1-bit full-add datapath built from two half-add stages (s1=a^b, c1=a&b; s=s1^c, c_next=c1|(s1&c)).
REQ-013 The block SHALL implement the states IDLE, RUN and DONE.
REQ-014 In IDLE, on an enabled edge with start=1, the block SHALL capture op_a/op_b into shift registers, clear the carry flop, clear the bit counter, and go to RUN.
REQ-015 In RUN, each enabled edge SHALL compute one bit, shift it into the result shift register MSB-side, shift both operand registers right by one, update the carry flop, and increment the counter.
REQ-016 On the enabled RUN edge that processes bit WIDTH-1, the block SHALL load sum with the full WIDTH-bit result and cout with the final carry, and go to DONE.
REQ-017 In DONE, done SHALL be 1; the next enabled edge SHALL return to IDLE unconditionally.
REQ-018 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE; both are decoded from registered state.
REQ-019 Latency SHALL be WIDTH+1 enabled edges from the start-accepting edge to done=1 (WIDTH=8: done high after edge 9).
REQ-020 start SHALL be ignored in RUN and DONE; no queuing.
REQ-021 sum and cout SHALL change only at the completion edge (REQ-016) and hold their value through IDLE, RUN and DONE until the next completion.
REQ-022 Arithmetic SHALL be unsigned modulo 2^WIDTH, with the overflow bit on cout ({cout,sum} = op_a+op_b exactly).
REQ-023 With ena=0 in any state, the block SHALL hold state, counter, carry, shift registers and outputs; done SHALL stay high if it was high (the pulse stretches).
REQ-024 op_a/op_b changes after the accepting edge SHALL NOT affect the result in progress.

Reset
REQ-025 When rst_n=0, the block SHALL asynchronously enter IDLE and clear busy=0, done=0, sum=0, cout=0, carry, counter and all shift registers, regardless of ena or clk.
REQ-026 Reset asserted mid-RUN SHALL abort the addition; no done pulse is generated, and sum/cout read 0.
REQ-027 After rst_n deasserts, the first enabled edge with start=1 SHALL be accepted normally.

Verification
REQ-028 WIDTH=8, op_a=0x00, op_b=0x00, start pulse -> busy high 8 cycles, done high on cycle 9, sum=0x00, cout=0.
REQ-029 op_a=0xFF, op_b=0x01 -> after done, sum=0x00, cout=1; op_a=0xA5, op_b=0x5A -> sum=0xFF, cout=0.
REQ-030 Start 0x12+0x34; re-assert start with 0xFF+0xFF during RUN -> second start ignored, sum=0x46, cout=0, one done pulse only.
REQ-031 Start 0x0F+0x01; hold ena=0 for 5 cycles mid-RUN -> done delayed by exactly 5 cycles, sum=0x10, cout=0.
REQ-032 Start 0x80+0x80; assert rst_n=0 after 4 RUN cycles -> busy=0 immediately, no done pulse, sum=0x00, cout=0; next start of 0x80+0x80 -> sum=0x00, cout=1.
REQ-033 Randomised back-to-back operands (start held high) -> one result per WIDTH+2 cycles, {cout,sum} equals the reference sum every time.
